// File: rtl/delay_arbiter.sv
// delay_arbiter: round-robin owner selection for the shared game delay timer.
// A 2 kHz tick is derived from clk_50M by a DIV-cycle prescaler; the granted
// requester's duration is counted down in ticks and a one-cycle done pulse is
// returned to it. Grant and done are registered one cycle behind the FSM state,
// so grant rises as RUN (or DONE for a zero delay) is entered and falls the
// edge after done.

// Per-requester output slot: registered grant and done bits for one requester.
module delay_arbiter_lane (
  input  logic clk_50M,
  input  logic i_Reset,
  input  logic sel,
  input  logic grant_en,
  input  logic done_en,
  output logic grant,
  output logic done
);

  // Grant and done follow the shared enables only when this slot is the owner.
  always_ff @(posedge clk_50M or negedge i_Reset) begin
    if (!i_Reset) begin
      grant <= 1'b0;
      done  <= 1'b0;
    end else begin
      grant <= grant_en & sel;
      done  <= done_en & sel;
    end
  end

endmodule

module delay_arbiter #(
  parameter int N_REQ = 3,
  parameter int WIDTH = 12,
  parameter int DIV   = 25000
) (
  input  logic                   clk_50M,
  input  logic                   i_Reset,
  input  logic [N_REQ-1:0]       i_Req,
  input  logic [N_REQ*WIDTH-1:0] i_Dur,
  output logic [N_REQ-1:0]       o_Grant,
  output logic [N_REQ-1:0]       o_Done,
  output logic                   o_Busy,
  output logic [WIDTH-1:0]       o_Count,
  output logic                   o_Tick
);

  localparam int IW = $clog2(N_REQ);
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   ptr_q, idx_q, win_idx;
  logic            win_vld;
  logic [PW-1:0]   presc_q;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] dur_sel;
  logic            abort, tick_hit, grant_en, done_en;

  assign dur_sel  = i_Dur[int'(idx_q)*WIDTH +: WIDTH];
  assign abort    = ((state_q == S_LOAD) || (state_q == S_RUN)) && !i_Req[idx_q];
  assign tick_hit = (presc_q == PRE_LAST);
  assign grant_en = (state_q != S_IDLE) && !abort;
  assign done_en  = (state_q == S_DONE);
  assign o_Count  = count_q;

  // Round-robin pick: first requester after the pointer, wrapping.
  always_comb begin
    win_vld = 1'b0;
    win_idx = ptr_q;
    for (int i = 1; i <= N_REQ; i++) begin
      if (!win_vld && i_Req[(int'(ptr_q) + i) % N_REQ]) begin
        win_vld = 1'b1;
        win_idx = IW'((int'(ptr_q) + i) % N_REQ);
      end
    end
  end

  // State register.
  always_ff @(posedge clk_50M or negedge i_Reset) begin
    if (!i_Reset) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic; an owner dropping its request aborts back to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (win_vld) state_d = S_LOAD;
      S_LOAD: begin
        if (abort)               state_d = S_IDLE;
        else if (dur_sel == '0)  state_d = S_DONE;
        else                     state_d = S_RUN;
      end
      S_RUN: begin
        if (abort)                                   state_d = S_IDLE;
        else if (tick_hit && count_q == WIDTH'(1))   state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Pointer, owner index, prescaler, tick counter, busy and tick pulse.
  always_ff @(posedge clk_50M or negedge i_Reset) begin
    if (!i_Reset) begin
      ptr_q   <= IW'(N_REQ - 1);
      idx_q   <= '0;
      presc_q <= '0;
      count_q <= '0;
      o_Tick  <= 1'b0;
      o_Busy  <= 1'b0;
    end else begin
      o_Busy <= (state_d != S_IDLE);
      o_Tick <= 1'b0;
      case (state_q)
        S_IDLE: begin
          presc_q <= '0;
          count_q <= '0;
          if (win_vld) begin
            idx_q <= win_idx;
            ptr_q <= win_idx;
          end
        end
        S_LOAD: begin
          presc_q <= '0;
          count_q <= abort ? '0 : dur_sel;
        end
        S_RUN: begin
          if (abort) begin
            presc_q <= '0;
            count_q <= '0;
          end else if (tick_hit) begin
            presc_q <= '0;
            o_Tick  <= 1'b1;
            if (count_q != '0) count_q <= count_q - WIDTH'(1);
          end else begin
            presc_q <= presc_q + PW'(1);
          end
        end
        default: begin
          presc_q <= '0;
          count_q <= '0;
        end
      endcase
    end
  end

  // One output slot per requester.
  for (genvar r = 0; r < N_REQ; r++) begin : g_lane
    delay_arbiter_lane u_lane (
      .clk_50M  (clk_50M),
      .i_Reset  (i_Reset),
      .sel      (idx_q == IW'(r)),
      .grant_en (grant_en),
      .done_en  (done_en),
      .grant    (o_Grant[r]),
      .done     (o_Done[r])
    );
  end

endmodule

// File: tb/tb_delay_arbiter.sv
// tb_delay_arbiter: directed stimulus with a grant/done scoreboard.
// Stimulus pushes expected grants and completions; a negedge monitor pops them
// as the DUT raises o_Grant / o_Done and checks latency, tick count and count.
module tb_delay_arbiter;

  localparam int N  = 3;
  localparam int W  = 12;
  localparam int DV = 4;

  typedef struct {
    logic [N-1:0] done;
    int           lat;
    int           nticks;
  } exp_t;

  logic             clk_50M = 1'b0;
  logic             i_Reset;
  logic [N-1:0]     i_Req;
  logic [N*W-1:0]   i_Dur;
  logic [N-1:0]     o_Grant, o_Done;
  logic             o_Busy, o_Tick;
  logic [W-1:0]     o_Count;

  int checks = 0;
  int errors = 0;

  logic [N-1:0] exp_grant_q[$];
  exp_t         exp_done_q[$];

  delay_arbiter #(.N_REQ(N), .WIDTH(W), .DIV(DV)) dut (
    .clk_50M (clk_50M),
    .i_Reset (i_Reset),
    .i_Req   (i_Req),
    .i_Dur   (i_Dur),
    .o_Grant (o_Grant),
    .o_Done  (o_Done),
    .o_Busy  (o_Busy),
    .o_Count (o_Count),
    .o_Tick  (o_Tick)
  );

  always #10 clk_50M = ~clk_50M;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic set_dur(input int r, input int v);
    i_Dur[r*W +: W] = W'(v);
  endtask

  task automatic push_job(input logic [N-1:0] g, input int lat, input int nt);
    exp_t e;
    e.done = g; e.lat = lat; e.nticks = nt;
    exp_grant_q.push_back(g);
    exp_done_q.push_back(e);
  endtask

  // Wait for o_Done[r], then drop that request within the done cycle.
  task automatic wait_done(input int r);
    int n = 0;
    do begin @(negedge clk_50M); n++; end while (!o_Done[r] && n < 200);
    if (!o_Done[r]) chk($sformatf("done_timeout_r%0d", r), 32'd0, 32'd1);
    i_Req[r] = 1'b0;
  endtask

  task automatic wait_grant(input logic [N-1:0] g);
    int n = 0;
    do begin @(negedge clk_50M); n++; end while (o_Grant != g && n < 200);
    if (o_Grant != g) chk("grant_timeout", 32'(o_Grant), 32'(g));
  endtask

  // Scoreboard monitor.
  int           cyc = 0, grant_cyc = 0, nticks = 0;
  logic [W-1:0] last_cnt = '0;
  logic [N-1:0] prev_grant = '0;
  always @(negedge clk_50M) begin
    exp_t e;
    cyc++;
    if (o_Grant != '0 && prev_grant == '0) begin
      if (exp_grant_q.size() == 0) chk("grant_unexpected", 32'(o_Grant), 32'd0);
      else chk("grant_order", 32'(o_Grant), 32'(exp_grant_q.pop_front()));
      grant_cyc = cyc;
      nticks    = 0;
      last_cnt  = o_Count;
    end
    if (o_Tick) begin
      nticks++;
      chk("tick_count_dec", 32'(o_Count), 32'(last_cnt) - 32'd1);
      last_cnt = o_Count;
    end
    if (o_Done != '0) begin
      if (exp_done_q.size() == 0) chk("done_unexpected", 32'(o_Done), 32'd0);
      else begin
        e = exp_done_q.pop_front();
        chk("done_vec", 32'(o_Done), 32'(e.done));
        chk("done_latency", 32'(cyc - grant_cyc), 32'(e.lat));
        chk("done_ticks", 32'(nticks), 32'(e.nticks));
        chk("done_grant_held", 32'(o_Grant), 32'(e.done));
      end
    end
    prev_grant = o_Grant;
  end

  initial begin
    i_Reset = 1'b0;
    i_Req   = '0;
    i_Dur   = '0;
    repeat (2) @(negedge clk_50M);
    i_Reset = 1'b1;
    @(negedge clk_50M);
    chk("rst_grant", 32'(o_Grant), 0);
    chk("rst_done",  32'(o_Done), 0);
    chk("rst_busy",  32'(o_Busy), 0);
    chk("rst_count", 32'(o_Count), 0);
    chk("rst_tick",  32'(o_Tick), 0);

    // Single requester 0, D=3: grant one edge after LOAD, done 13 cycles later.
    set_dur(0, 3);
    push_job(3'b001, 3*DV+1, 3);
    i_Req = 3'b001;
    @(negedge clk_50M);
    chk("t1_load_busy",  32'(o_Busy), 1);
    chk("t1_load_grant", 32'(o_Grant), 0);
    @(negedge clk_50M);
    chk("t1_grant",      32'(o_Grant), 32'b001);
    chk("t1_count_load", 32'(o_Count), 3);
    wait_done(0);
    @(negedge clk_50M);
    chk("t1_grant_fall", 32'(o_Grant), 0);
    chk("t1_done_single", 32'(o_Done), 0);

    // Fresh reset, three simultaneous D=1 requests, requester 0 re-requests.
    i_Reset = 1'b0;
    @(negedge clk_50M);
    i_Reset = 1'b1;
    for (int r = 0; r < N; r++) set_dur(r, 1);
    push_job(3'b001, DV+1, 1);
    push_job(3'b010, DV+1, 1);
    push_job(3'b100, DV+1, 1);
    push_job(3'b001, DV+1, 1);
    i_Req = 3'b111;
    wait_done(0);
    @(negedge clk_50M);
    i_Req[0] = 1'b1;
    wait_done(1);
    wait_done(2);
    wait_done(0);

    // Zero duration on requester 1: grant then done next cycle, no ticks.
    set_dur(1, 0);
    push_job(3'b010, 1, 0);
    i_Req[1] = 1'b1;
    wait_grant(3'b010);
    chk("t3_count_zero", 32'(o_Count), 0);
    chk("t3_no_tick",    32'(o_Tick), 0);
    wait_done(1);

    // Abort: requester 2 drops after 6 RUN cycles, pending requester 0 follows.
    set_dur(2, 5);
    set_dur(0, 2);
    exp_grant_q.push_back(3'b100);
    i_Req[2] = 1'b1;
    wait_grant(3'b100);
    i_Req[0] = 1'b1;
    repeat (5) @(negedge clk_50M);
    chk("t4_precount", 32'(o_Count), 4);
    push_job(3'b001, 2*DV+1, 2);
    i_Req[2] = 1'b0;
    @(negedge clk_50M);
    chk("t4_abort_grant", 32'(o_Grant), 0);
    chk("t4_abort_count", 32'(o_Count), 0);
    chk("t4_abort_busy",  32'(o_Busy), 0);
    chk("t4_abort_done",  32'(o_Done), 0);
    wait_done(0);

    // Async reset mid-RUN at count 2, then requester 0 beats requester 1.
    set_dur(0, 3);
    exp_grant_q.push_back(3'b001);
    i_Req[0] = 1'b1;
    begin
      int n = 0;
      do begin @(negedge clk_50M); n++; end while (o_Count != W'(2) && n < 200);
      chk("t5_reach_count2", 32'(o_Count), 2);
    end
    #3 i_Reset = 1'b0;
    #1;
    chk("t5_rst_grant", 32'(o_Grant), 0);
    chk("t5_rst_count", 32'(o_Count), 0);
    chk("t5_rst_busy",  32'(o_Busy), 0);
    chk("t5_rst_tick",  32'(o_Tick), 0);
    set_dur(0, 1);
    set_dur(1, 1);
    i_Req = 3'b011;
    push_job(3'b001, DV+1, 1);
    push_job(3'b010, DV+1, 1);
    @(negedge clk_50M);
    i_Reset = 1'b1;
    wait_done(0);
    wait_done(1);

    repeat (5) @(negedge clk_50M);
    chk("grant_q_drained", 32'(exp_grant_q.size()), 0);
    chk("done_q_drained",  32'(exp_done_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/delay_arbiter.md
# delay_arbiter

Round-robin arbiter and sequencer for the game's single shared delay timer. Requesters (player FSM, dealer FSM, display sequencer) each ask for a timed pause of a programmable number of 2 kHz ticks; the block grants the timer to one requester at a time, derives the 2 kHz tick from the 50 MHz clock, counts the delay down and returns a one-cycle completion pulse to the winner. It replaces per-FSM ad-hoc 2-second counters.

## Interface
- N_REQ, 3: number of requesters (2..8)
- WIDTH, 12: tick-count width; max delay 2^WIDTH-1 ticks (4000 ticks = 2 s)
- DIV, 25000: clk_50M cycles per tick (2 kHz); bench may override with a small value

- clk_50M  in  1  50 MHz clock, all state on rising edge
- i_Reset  in  1  asynchronous, active-low reset
- i_Req  in  N_REQ  request bit per requester; held high until its o_Done pulse
- i_Dur  in  N_REQ*WIDTH  delay in ticks, requester r at bits [r*WIDTH +: WIDTH]; sampled only in LOAD
- o_Grant  out  N_REQ  one-hot, current timer owner; 0 when idle
- o_Done  out  N_REQ  one-cycle completion pulse to owner
- o_Busy  out  1  high in LOAD, RUN, DONE
- o_Count  out  WIDTH  remaining ticks; 0 outside RUN
- o_Tick  out  1  one-cycle pulse at each tick boundary, RUN only

## Operation
- FSM states: IDLE, LOAD, RUN, DONE. All outputs registered.
- Reset (i_Reset low, async): state IDLE, round-robin pointer = N_REQ-1 (requester 0 wins first), prescaler 0, all outputs 0.
- IDLE: if any i_Req high, select first requesting index scanning from pointer+1 upward, wrapping modulo N_REQ; latch index, set pointer to it, go LOAD. No request: stay.
- LOAD (1 cycle): o_Grant one-hot on winner; count <= i_Dur of winner; prescaler <= 0. If that i_Dur = 0, go DONE directly; else go RUN.
- RUN: prescaler increments each cycle; when prescaler = DIV-1: prescaler <= 0, o_Tick pulses, count decrements. When count decrements from 1 to 0, go DONE.
- DONE (1 cycle): o_Done[winner] = 1, o_Grant still set; next state IDLE, grant cleared.
- Abort: winner's i_Req low in LOAD or RUN -> next edge IDLE, grant 0, count 0, prescaler 0, no o_Done. Pointer keeps the aborted index.
- Requests from non-owners are ignored while busy; they stay pending (held high) and are arbitrated in IDLE.
- Owner must drop i_Req the cycle after o_Done; a still-high request in IDLE is a new request and competes normally (other pending requesters win first).
- i_Dur changes after LOAD have no effect. Count never wraps below 0.

## Timing
- i_Req sampled high in IDLE at edge k -> o_Grant high after edge k+1.
- o_Done high exactly D*DIV+1 cycles after o_Grant rises (D = latched duration); D=0 gives 1 cycle.
- o_Grant falls on the edge after o_Done; minimum gap between two grants is 1 IDLE cycle.
- o_Tick pulses coincide with the o_Count decrement edge; first o_Tick DIV cycles after entering RUN.
- o_Busy = (state != IDLE), registered with the state.
- Reset mid-operation: all outputs 0 immediately (async), no o_Done emitted.

## Test plan
- DIV=4, single requester 0, D=3: grant 1 cycle after req; o_Tick at RUN cycles 4, 8, 12; o_Count 3->2->1->0; o_Done[0] 13 cycles after grant, single cycle.
- DIV=4, requesters 0,1,2 all request D=1 simultaneously and re-request after done: grant order 0,1,2,0; each o_Done to the matching bit only.
- D=0 on requester 1: o_Grant=3'b010 then o_Done[1] next cycle, no o_Tick, o_Count stays 0.
- Abort: requester 2, D=5, DIV=4, drop i_Req after 6 RUN cycles -> next edge grant 0, o_Count 0, no o_Done; pending requester 0 granted next.
- Async reset asserted mid-RUN with o_Count=2: outputs 0 without clock edge; after release requester 0 has priority over simultaneous requester 1.
- Default DIV=25000, D=4000: o_Done 100,000,001 cycles after grant (2 s).
